lfsr_parallel: RTL and testbench
================================

Name: lfsr_parallel

Overview:
- Parallel (multi-bit-per-step) LFSR engine. It advances a LFSR_WIDTH-bit shift register by DATA_WIDTH bit-steps in one evaluation.
- Usable as a CRC engine (e.g. Ethernet CRC-32 over 128-bit XGMII words), a scrambler/descrambler, or a PRBS generator.
- The datapath is pure XOR logic with an optional output register. Callers keep the running state externally and feed it back through state_in.

Parameters:
- LFSR_WIDTH, 31: state width in bits.
- LFSR_POLY, 31'h10000001: feedback polynomial, implicit x^LFSR_WIDTH term omitted, bit j = coefficient of x^j.
- LFSR_CONFIG, "FIBONACCI": "FIBONACCI" or "GALOIS"; any other value is an elaboration error.
- LFSR_FEED_FORWARD, 0: 0 = feedback (generator/scrambler/CRC); 1 = feed-forward (self-synchronising descrambler).
- REVERSE, 0: 1 = bit-reverse both state and data ordering (LSB-first, as for Ethernet CRC).
- DATA_WIDTH, 8: bits processed per evaluation (≥1).
- STYLE, "AUTO": implementation style "AUTO", "LOOP" or "REDUCTION"; all are functionally identical; any other value is an elaboration error.
- REG_OUTPUT, 0: 0 = combinational outputs; 1 = outputs registered with one cycle latency.

Ports:
- clk, input, 1: clock; used only when REG_OUTPUT=1.
- rst, input, 1: reset, synchronous, active-high; clock clk; used only when REG_OUTPUT=1.
- data_in, input, DATA_WIDTH: data bits shifted in.
- state_in, input, LFSR_WIDTH: current LFSR state.
- data_out, output, DATA_WIDTH: generated/scrambled output bits; may be left unconnected.
- state_out, output, LFSR_WIDTH: state after DATA_WIDTH steps.

Behaviour:
- The result must equal DATA_WIDTH sequential single-bit steps, starting from s = state_in.
- Bit order, REVERSE=0: data_in[DATA_WIDTH-1] is consumed first; the first output bit goes to data_out[DATA_WIDTH-1]; state bit indices are as given.
- Bit order, REVERSE=1: data_in[0] is consumed first and the first output bit goes to data_out[0]. The state is viewed bit-reversed: internal s[k] = state_in[LFSR_WIDTH-1-k], and state_out is reversed likewise.
- Single step, input bit d, W = LFSR_WIDTH.
- FIBONACCI:
  - fb = s[W-1] ^ d ^ XOR over j in 1..W-1 with LFSR_POLY[j]=1 of s[j-1].
  - Output bit = fb.
  - Shift-in bit b = fb if FEED_FORWARD=0, else b = d.
  - Next state s = {s[W-2:0], b}.
- GALOIS:
  - fb = s[W-1] ^ d; output bit = fb.
  - Tap value t = fb if FEED_FORWARD=0, else t = d.
  - Next state s = {s[W-2:0], t}, then for each j in 1..W-1 with LFSR_POLY[j]=1, s[j] ^= t.
- REG_OUTPUT=0: outputs are purely combinational functions of data_in and state_in, with zero latency; clk and rst are ignored.
- REG_OUTPUT=1: data_out and state_out are registered on posedge clk, one cycle after the inputs.
  - rst high at a clock edge forces both outputs to all-zero on that edge, overriding the new result.
  - After reset the outputs are zero until the first non-reset edge.
- The mapping is linear over GF(2). Implementations precompute per-output-bit XOR masks at elaboration (loop or reduction style). No run-time state exists other than the optional output register.
- There is no handshake; the caller controls when to feed state_out back into state_in.
- Edge cases:
  - LFSR_POLY bit 0 is ignored (the implicit x^0 term is the feedback itself).
  - With state_in = 0 and data_in = 0, all outputs are 0.

Test Plan:
- CRC-32 check value: LFSR_WIDTH=32, POLY=32'h04C11DB7, GALOIS, FF=0, REVERSE=1, DATA_WIDTH=8, state FFFFFFFF. Chain ASCII "123456789" byte by byte → ~state_out = 32'hCBF43926.
- CRC-32 residue, same configuration but DATA_WIDTH=128: process a 64-byte Ethernet frame including its correct FCS in four words → final state_out = 32'hDEBB20E3. Corrupt one data bit → state_out differs.
- Scrambler round-trip: LFSR_WIDTH=58, POLY=58'h8000000001, FIBONACCI, REVERSE=1, DATA_WIDTH=64. Run a scrambler (FF=0) and a descrambler (FF=1), both starting from state 58'h3FFFFFFFFFFFFFF, over 16 random words → descrambler data_out equals the original words every word, and the two state_outs match.
- PRBS31 generator: LFSR_WIDTH=31, POLY=31'h10000001, FIBONACCI, FF=0, data_in=0, DATA_WIDTH=1, state 31'h7FFFFFFF. Compare against a bit-serial reference model for 1000 steps. Then use DATA_WIDTH=32 → identical bit stream.
- Galois/LOOP equivalence: same random inputs with STYLE="LOOP" and STYLE="REDUCTION" → identical outputs.
- REG_OUTPUT=1: assert rst for 2 cycles → outputs 0. Then apply inputs → outputs equal the combinational result exactly one cycle later. Assert rst mid-stream → outputs 0 on the next edge.

Source files
------------

// File: rtl/lfsr_parallel.sv
// Parallel LFSR engine: advances an LFSR_WIDTH-bit shift register by DATA_WIDTH bit-steps at once.
// Every output bit is an elaboration-time XOR mask over {data_in, state_in}; optional output register.
module lfsr_parallel #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = "AUTO",
  parameter bit                    REG_OUTPUT        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int M         = LFSR_WIDTH + DATA_WIDTH;
  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");
  localparam bit USE_LOOP  = (STYLE == "LOOP");

  // Mask row r selects which bits of {data_in, state_in} are XORed into output r.
  // Rows [LFSR_WIDTH-1:0] feed state_out, rows [M-1:LFSR_WIDTH] feed data_out.
  typedef logic [M-1:0]  mask_t;
  typedef mask_t [M-1:0] mask_table_t;

  // Symbolic bit-serial run: each state bit carries the set of input bits it depends on.
  function automatic mask_table_t build_masks();
    mask_t [LFSR_WIDTH-1:0] s;
    mask_table_t            tbl;
    mask_t                  d;
    mask_t                  fb;
    mask_t                  t;
    int                     pos;
    tbl = '0;
    for (int k = 0; k < LFSR_WIDTH; k++) begin
      s[k] = mask_t'(1) << (REVERSE ? LFSR_WIDTH - 1 - k : k);
    end
    for (int n = 0; n < DATA_WIDTH; n++) begin
      pos = REVERSE ? n : DATA_WIDTH - 1 - n;
      d   = mask_t'(1) << (LFSR_WIDTH + pos);
      fb  = s[LFSR_WIDTH-1] ^ d;
      if (IS_GALOIS) begin
        t = LFSR_FEED_FORWARD ? d : fb;
        for (int k = LFSR_WIDTH - 1; k > 0; k--) begin
          s[k] = s[k-1] ^ (LFSR_POLY[k] ? t : mask_t'(0));
        end
        s[0] = t;
      end else begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb = fb ^ s[j-1];
        end
        for (int k = LFSR_WIDTH - 1; k > 0; k--) begin
          s[k] = s[k-1];
        end
        s[0] = LFSR_FEED_FORWARD ? d : fb;
      end
      tbl[LFSR_WIDTH + pos] = fb;
    end
    for (int k = 0; k < LFSR_WIDTH; k++) begin
      tbl[REVERSE ? LFSR_WIDTH - 1 - k : k] = s[k];
    end
    return tbl;
  endfunction

  localparam mask_table_t MASKS = build_masks();

  if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "GALOIS") begin : g_bad_config
    $error("lfsr_parallel: LFSR_CONFIG must be \"FIBONACCI\" or \"GALOIS\"");
  end
  if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
    $error("lfsr_parallel: STYLE must be \"AUTO\", \"LOOP\" or \"REDUCTION\"");
  end
  if (DATA_WIDTH < 1 || LFSR_WIDTH < 1) begin : g_bad_width
    $error("lfsr_parallel: LFSR_WIDTH and DATA_WIDTH must be at least 1");
  end

  logic [M-1:0]          in_vec;
  logic [LFSR_WIDTH-1:0] state_next;
  logic [DATA_WIDTH-1:0] data_next;

  assign in_vec = {data_in, state_in};

  if (USE_LOOP) begin : g_loop
    always_comb begin
      // NOTE: both results are defaulted before the loops so no path leaves them unassigned
      // (no latch), and the running XOR uses blocking '=' because later iterations read it.
      state_next = '0;
      data_next  = '0;
      for (int i = 0; i < LFSR_WIDTH; i++) begin
        for (int j = 0; j < M; j++) begin
          if (MASKS[i][j]) state_next[i] = state_next[i] ^ in_vec[j];
        end
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
        for (int j = 0; j < M; j++) begin
          if (MASKS[LFSR_WIDTH+i][j]) data_next[i] = data_next[i] ^ in_vec[j];
        end
      end
    end
  end else begin : g_reduction
    for (genvar i = 0; i < LFSR_WIDTH; i++) begin : g_state_bit
      assign state_next[i] = ^(MASKS[i] & in_vec);
    end
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_data_bit
      assign data_next[i] = ^(MASKS[LFSR_WIDTH+i] & in_vec);
    end
  end

  if (REG_OUTPUT) begin : g_reg
    // NOTE: reset is synchronous and takes priority over the new result on the same edge;
    // the register holds state, so it is updated with non-blocking '<='.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_out <= '0;
        data_out  <= '0;
      end else begin
        state_out <= state_next;
        data_out  <= data_next;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign state_out      = state_next;
    assign data_out       = data_next;
  end

endmodule

// File: tb/tb_lfsr_parallel.sv
// Self-checking bench for lfsr_parallel: CRC-32, 64b/66b-style scrambler, PRBS31, Galois styles
// and registered outputs, all checked against arithmetic reference models kept here.
module tb_lfsr_parallel;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reflected CRC-32 register update for one byte (no final inversion).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Bit-serial LFSR, MSB-first data, plain integer shifts (REVERSE=0, feedback mode).
  function automatic void ref_lfsr(input bit galois, input int w, input int dw,
                                   input logic [63:0] poly, input logic [63:0] st,
                                   input logic [127:0] din,
                                   output logic [63:0] st_o, output logic [127:0] dout);
    logic [63:0] s;
    logic [63:0] wmask;
    logic        fb;
    wmask = (64'd1 << w) - 64'd1;
    s     = st & wmask;
    dout  = '0;
    for (int n = 0; n < dw; n++) begin
      fb = s[w-1] ^ din[dw-1-n];
      if (!galois) fb = fb ^ (^(s & (poly >> 1) & wmask));
      dout[dw-1-n] = fb;
      if (galois) s = ((s << 1) ^ (fb ? (poly | 64'd1) : 64'd0)) & wmask;
      else        s = ((s << 1) | {63'd0, fb}) & wmask;
    end
    st_o = s;
  endfunction

  // CRC-32, 8 bits per step
  logic [7:0]  c8_din, c8_dout_unused;
  logic [31:0] c8_sin, c8_sout;
  lfsr_parallel #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
                  .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(8)) u_crc8 (
    .clk(clk), .rst(rst), .data_in(c8_din), .state_in(c8_sin),
    .data_out(c8_dout_unused), .state_out(c8_sout));

  // CRC-32, 128 bits per step
  logic [127:0] c128_din, c128_dout_unused;
  logic [31:0]  c128_sin, c128_sout;
  lfsr_parallel #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
                  .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(128)) u_crc128 (
    .clk(clk), .rst(rst), .data_in(c128_din), .state_in(c128_sin),
    .data_out(c128_dout_unused), .state_out(c128_sout));

  // Scrambler / self-synchronising descrambler pair
  logic [63:0] scr_din, scr_dout, dsc_din, dsc_dout;
  logic [57:0] scr_sin, scr_sout, dsc_sin, dsc_sout;
  assign dsc_din = scr_dout;
  lfsr_parallel #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
                  .LFSR_FEED_FORWARD(1'b0), .REVERSE(1'b1), .DATA_WIDTH(64)) u_scr (
    .clk(clk), .rst(rst), .data_in(scr_din), .state_in(scr_sin),
    .data_out(scr_dout), .state_out(scr_sout));
  lfsr_parallel #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_CONFIG("FIBONACCI"),
                  .LFSR_FEED_FORWARD(1'b1), .REVERSE(1'b1), .DATA_WIDTH(64)) u_dsc (
    .clk(clk), .rst(rst), .data_in(dsc_din), .state_in(dsc_sin),
    .data_out(dsc_dout), .state_out(dsc_sout));

  // PRBS31, 1 and 32 bits per step
  logic [0:0]  p1_din, p1_dout;
  logic [30:0] p1_sin, p1_sout;
  lfsr_parallel #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .DATA_WIDTH(1)) u_prbs1 (
    .clk(clk), .rst(rst), .data_in(p1_din), .state_in(p1_sin),
    .data_out(p1_dout), .state_out(p1_sout));
  logic [31:0] p32_din, p32_dout;
  logic [30:0] p32_sin, p32_sout;
  lfsr_parallel #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .DATA_WIDTH(32)) u_prbs32 (
    .clk(clk), .rst(rst), .data_in(p32_din), .state_in(p32_sin),
    .data_out(p32_dout), .state_out(p32_sout));

  // Galois CRC-16/CCITT, both implementation styles on the same inputs
  logic [11:0] g_din, gr_dout, gl_dout;
  logic [15:0] g_sin, gr_sout, gl_sout;
  lfsr_parallel #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"),
                  .DATA_WIDTH(12), .STYLE("REDUCTION")) u_gal_red (
    .clk(clk), .rst(rst), .data_in(g_din), .state_in(g_sin),
    .data_out(gr_dout), .state_out(gr_sout));
  lfsr_parallel #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"),
                  .DATA_WIDTH(12), .STYLE("LOOP")) u_gal_loop (
    .clk(clk), .rst(rst), .data_in(g_din), .state_in(g_sin),
    .data_out(gl_dout), .state_out(gl_sout));

  // Registered outputs, default polynomial
  logic [7:0]  r_din, r_dout;
  logic [30:0] r_sin, r_sout;
  lfsr_parallel #(.REG_OUTPUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .data_in(r_din), .state_in(r_sin),
    .data_out(r_dout), .state_out(r_sout));

  logic [7:0]   frame [64];
  logic [31:0]  crc;
  logic [31:0]  fcs;
  string        msg;
  bit           hist [$];
  bit           prbs_ref [1024];
  logic [63:0]  word, exp_scr;
  logic [57:0]  exp_scr_state;
  logic [63:0]  ms;
  logic [127:0] md;
  logic [30:0]  prev_s, exp_p_state;
  logic [7:0]   prev_d;
  logic [31:0]  exp_p32;
  bit           b;

  task automatic run_frame(input string tag, input bit good);
    logic [31:0] m;
    m        = 32'hFFFFFFFF;
    c128_sin = 32'hFFFFFFFF;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 16; k++) begin
        c128_din[8*k +: 8] = frame[16*w+k];
        m = crc32_byte(m, frame[16*w+k]);
      end
      #1;
      check($sformatf("%s_word%0d", tag, w), c128_sout, m);
      if (w == 3) check({tag, "_residue_match"}, c128_sout == 32'hDEBB20E3, good);
      c128_sin = c128_sout;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    c8_din = '0; c8_sin = '0; c128_din = '0; c128_sin = '0;
    scr_din = '0; scr_sin = '0; dsc_sin = '0;
    p1_din = '0; p1_sin = '0; p32_din = '0; p32_sin = '0;
    g_din = '0; g_sin = '0; r_din = '0; r_sin = '0;

    // CRC-32 check value over "123456789"
    msg    = "123456789";
    crc    = 32'hFFFFFFFF;
    c8_sin = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      c8_din = msg[i];
      crc    = crc32_byte(crc, msg[i]);
      #1;
      check($sformatf("crc8_byte%0d", i), c8_sout, crc);
      if (i == 8) check("crc32_check_value", 32'(~c8_sout), 32'hCBF43926);
      c8_sin = c8_sout;
    end

    // 64-byte frame with FCS: residue, then one corrupted bit
    for (int i = 0; i < 60; i++) frame[i] = 8'($urandom);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) crc = crc32_byte(crc, frame[i]);
    fcs = ~crc;
    for (int k = 0; k < 4; k++) frame[60+k] = fcs[8*k +: 8];
    run_frame("frame_good", 1'b1);
    frame[23] = frame[23] ^ 8'h08;
    run_frame("frame_bad", 1'b0);

    // Scrambler / descrambler round trip; history holds past scrambled bits, oldest first
    scr_sin = '1;
    dsc_sin = '1;
    hist.delete();
    for (int i = 0; i < 58; i++) hist.push_back(1'b1);
    for (int w = 0; w < 16; w++) begin
      word    = {$urandom, $urandom};
      scr_din = word;
      for (int n = 0; n < 64; n++) begin
        b = word[n] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
        exp_scr[n] = b;
        hist.push_back(b);
        void'(hist.pop_front());
      end
      for (int j = 0; j < 58; j++) exp_scr_state[j] = hist[j];
      #1;
      check($sformatf("scr_data%0d", w), scr_dout, exp_scr);
      check($sformatf("dsc_data%0d", w), dsc_dout, word);
      check($sformatf("scr_state%0d", w), scr_sout, exp_scr_state);
      check($sformatf("dsc_state%0d", w), dsc_sout, exp_scr_state);
      scr_sin = scr_sout;
      dsc_sin = dsc_sout;
    end

    // PRBS31 reference stream: b[n] = b[n-31] ^ b[n-28]
    hist.delete();
    for (int i = 0; i < 31; i++) hist.push_back(1'b1);
    for (int i = 0; i < 1024; i++) begin
      b = hist[hist.size()-31] ^ hist[hist.size()-28];
      prbs_ref[i] = b;
      hist.push_back(b);
      void'(hist.pop_front());
    end
    p1_sin = 31'h7FFFFFFF;
    for (int i = 0; i < 1000; i++) begin
      #1;
      check($sformatf("prbs1_bit%0d", i), p1_dout, prbs_ref[i]);
      if (i == 999) begin
        for (int k = 0; k < 31; k++) exp_p_state[k] = prbs_ref[999-k];
        check("prbs1_state", p1_sout, exp_p_state);
      end
      p1_sin = p1_sout;
    end
    p32_sin = 31'h7FFFFFFF;
    for (int w = 0; w < 32; w++) begin
      for (int n = 0; n < 32; n++) exp_p32[31-n] = prbs_ref[32*w+n];
      #1;
      check($sformatf("prbs32_word%0d", w), p32_dout, exp_p32);
      if (w == 31) begin
        for (int k = 0; k < 31; k++) exp_p_state[k] = prbs_ref[1023-k];
        check("prbs32_state", p32_sout, exp_p_state);
      end
      p32_sin = p32_sout;
    end

    // Galois, LOOP and REDUCTION styles; first vector is the all-zero case
    for (int i = 0; i < 12; i++) begin
      g_sin = (i == 0) ? 16'd0 : 16'($urandom);
      g_din = (i == 0) ? 12'd0 : 12'($urandom);
      ref_lfsr(1'b1, 16, 12, 64'h1021, {48'd0, g_sin}, {116'd0, g_din}, ms, md);
      #1;
      check($sformatf("gal_red_state%0d", i), gr_sout, ms[15:0]);
      check($sformatf("gal_red_data%0d", i), gr_dout, md[11:0]);
      check($sformatf("gal_loop_state%0d", i), gl_sout, ms[15:0]);
      check($sformatf("gal_loop_data%0d", i), gl_dout, md[11:0]);
    end

    // Registered outputs: reset, one-cycle latency, mid-stream reset
    rst   = 1'b1;
    r_sin = 31'($urandom) | 31'd1;
    r_din = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("reg_rst_state", r_sout, 31'd0);
    check("reg_rst_data", r_dout, 8'd0);
    rst = 1'b0;
    #1;
    check("reg_zero_before_edge", r_sout, 31'd0);
    prev_s = '0;
    prev_d = '0;
    for (int i = 0; i < 20; i++) begin
      r_sin = 31'($urandom);
      r_din = 8'($urandom);
      ref_lfsr(1'b0, 31, 8, 64'h10000001, {33'd0, r_sin}, {120'd0, r_din}, ms, md);
      #1;
      check($sformatf("reg_hold_state%0d", i), r_sout, prev_s);
      check($sformatf("reg_hold_data%0d", i), r_dout, prev_d);
      @(posedge clk);
      #1;
      check($sformatf("reg_state%0d", i), r_sout, ms[30:0]);
      check($sformatf("reg_data%0d", i), r_dout, md[7:0]);
      prev_s = ms[30:0];
      prev_d = md[7:0];
      if (i == 9) begin
        rst   = 1'b1;
        r_sin = 31'h7FFFFFFF;
        r_din = 8'hA5;
        @(posedge clk);
        #1;
        check("reg_midrst_state", r_sout, 31'd0);
        check("reg_midrst_data", r_dout, 8'd0);
        rst    = 1'b0;
        prev_s = '0;
        prev_d = '0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
